// File: rtl/inst_ram_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : inst_ram_arb_pkg                                             |
// | Description : Shared types and constants for the instruction RAM arbiter. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package inst_ram_arb_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 32;

  // Port ids double as grant-vector indices and round-robin pointer values
  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LOAD  = 1'b1;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/inst_ram_arbiter_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_arb2                                                      |
// | Description : Two-request round-robin arbiter; pointer flips on contention.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rr_arb2
  import inst_ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic       r_ptr;
  logic [1:0] w_req;
  logic       w_contend;

  assign w_req     = i_req & {2{i_en}};
  assign w_contend = &w_req;

  always_comb begin
    o_gnt = w_req;
    if (w_contend) begin
      o_gnt        = 2'b00;
      o_gnt[r_ptr] = 1'b1;
    end
  end

  // Uncontended grants leave the pointer alone so a lone requester cannot
  // steal the other port's next turn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= PORT_FETCH;
    end else if (w_contend) begin
      r_ptr <= ~r_ptr;
    end
  end

endmodule
`default_nettype wire

// File: rtl/inst_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : inst_ram_arbiter                                             |
// | Description : Shares a single-port instruction RAM between fetch and       |
// |               loader ports. Define INST_RAM_ARB_CLEAR_EN to zero the RAM   |
// |               with a full sweep after every reset.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module inst_ram_arbiter
  import inst_ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              f_valid,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ready,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              l_valid,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  input  logic              l_lock,
  output logic              l_ready,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  logic              w_clear;
  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_din;
  logic              w_ram_we;
  logic [ADDR_W-1:0] r_addr;
  logic              r_f_rvalid;
  logic              r_l_rvalid;
  logic [DATA_W-1:0] r_f_rdata;
  logic [DATA_W-1:0] r_l_rdata;

`ifdef INST_RAM_ARB_CLEAR_EN
  localparam logic [ADDR_W-1:0] c_sweep_one = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [ADDR_W-1:0] r_sweep;

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      r_state <= ST_CLEAR;
      r_sweep <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_sweep <= r_sweep + c_sweep_one;
          if (&r_sweep) r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign w_clear = (r_state == ST_CLEAR);
`else
  assign w_clear = 1'b0;
`endif

  // Fetch is masked by the loader lock before arbitration, so a locked fetch
  // never contends and never moves the pointer.
  assign w_req[PORT_FETCH] = f_valid & ~l_lock;
  assign w_req[PORT_LOAD]  = l_valid;

  rr_arb2 u_arb (
    .clk   (clka),
    .rst   (rsta),
    .i_en  (~w_clear & ~rsta),
    .i_req (w_req),
    .o_gnt (w_gnt)
  );

  always_comb begin
    w_ram_addr = r_addr;
    w_ram_din  = l_wdata;
    w_ram_we   = 1'b0;
`ifdef INST_RAM_ARB_CLEAR_EN
    if (w_clear) begin
      w_ram_addr = r_sweep;
      w_ram_din  = '0;
      w_ram_we   = 1'b1;
    end else
`endif
    if (w_gnt[PORT_LOAD]) begin
      w_ram_addr = l_addr;
      w_ram_we   = l_we;
    end else if (w_gnt[PORT_FETCH]) begin
      w_ram_addr = f_addr;
    end
  end

  // RAM reads are combinational, so the word returned is whatever ram_dout
  // shows during the accept cycle (the old word for a loader write).
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      r_addr     <= '0;
      r_f_rvalid <= 1'b0;
      r_l_rvalid <= 1'b0;
      r_f_rdata  <= '0;
      r_l_rdata  <= '0;
    end else begin
      r_addr     <= w_ram_addr;
      r_f_rvalid <= w_gnt[PORT_FETCH];
      r_l_rvalid <= w_gnt[PORT_LOAD];
      if (w_gnt[PORT_FETCH]) r_f_rdata <= ram_dout;
      if (w_gnt[PORT_LOAD])  r_l_rdata <= ram_dout;
    end
  end

  assign f_ready  = w_gnt[PORT_FETCH];
  assign l_ready  = w_gnt[PORT_LOAD];
  assign f_rvalid = r_f_rvalid;
  assign l_rvalid = r_l_rvalid;
  assign f_rdata  = r_f_rdata;
  assign l_rdata  = r_l_rdata;
  assign busy     = w_clear;
  assign ram_addr = w_ram_addr;
  assign ram_din  = w_ram_din;
  assign ram_we   = w_ram_we;

endmodule
`default_nettype wire

// File: tb/tb_inst_ram_arbiter.sv
`default_nettype none
// Bench for inst_ram_arbiter: RAM model, spec-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_inst_ram_arbiter;

`ifdef INST_RAM_ARB_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif
  localparam int DEPTH = 512;

  logic        clka = 1'b0;
  logic        rsta;
  logic        f_valid, f_ready, f_rvalid;
  logic [8:0]  f_addr;
  logic [31:0] f_rdata;
  logic        l_valid, l_we, l_lock, l_ready, l_rvalid;
  logic [8:0]  l_addr;
  logic [31:0] l_wdata, l_rdata;
  logic        busy, ram_we;
  logic [8:0]  ram_addr;
  logic [31:0] ram_din, ram_dout;

  int checks = 0;
  int errors = 0;

  always #5 clka = ~clka;

  inst_ram_arbiter dut (
    .clka(clka), .rsta(rsta),
    .f_valid(f_valid), .f_addr(f_addr), .f_ready(f_ready),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_valid(l_valid), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_lock(l_lock), .l_ready(l_ready), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .busy(busy), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i * 32'h9E3779B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM macro: combinational read, write at the clock edge (read-first).
  logic [31:0] mem [DEPTH];
  assign ram_dout = mem[ram_addr];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clka);
      if (ram_we) mem[ram_addr] <= ram_din;
    end
  end

  // Reference model, evaluated mid-cycle (negedge) against the DUT.
  logic [31:0] exp_mem [DEPTH];
  initial begin
    bit          m_ptr, pend_f, pend_l, in_clear, fe, le;
    int          win, clr_cnt;
    logic [8:0]  last_addr;
    logic [31:0] exp_frd, exp_lrd;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = init_word(i);
    m_ptr = 0; pend_f = 0; pend_l = 0; exp_frd = 0; exp_lrd = 0;
    last_addr = 0; clr_cnt = 0; in_clear = CLR;
    forever begin
      @(negedge clka);
      if (rsta) begin
        chk("rst_f_ready", f_ready, 0);
        chk("rst_l_ready", l_ready, 0);
        chk("rst_f_rvalid", f_rvalid, 0);
        chk("rst_l_rvalid", l_rvalid, 0);
        chk("rst_f_rdata", f_rdata, 0);
        chk("rst_l_rdata", l_rdata, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_busy", busy, CLR);
        chk("rst_ram_we", ram_we, CLR);
        m_ptr = 0; pend_f = 0; pend_l = 0; exp_frd = 0; exp_lrd = 0;
        last_addr = 0; clr_cnt = 0; in_clear = CLR;
        if (CLR) exp_mem[0] = 0;
      end else begin
        chk("f_rvalid", f_rvalid, pend_f);
        chk("l_rvalid", l_rvalid, pend_l);
        chk("f_rdata", f_rdata, exp_frd);
        chk("l_rdata", l_rdata, exp_lrd);
        pend_f = 0; pend_l = 0;
        if (in_clear) begin
          chk("clr_busy", busy, 1);
          chk("clr_f_ready", f_ready, 0);
          chk("clr_l_ready", l_ready, 0);
          chk("clr_ram_we", ram_we, 1);
          chk("clr_ram_addr", ram_addr, clr_cnt);
          chk("clr_ram_din", ram_din, 0);
          exp_mem[clr_cnt] = 0;
          last_addr = 9'(clr_cnt);
          clr_cnt++;
          if (clr_cnt == DEPTH) in_clear = 0;
        end else begin
          fe = f_valid && !l_lock;
          le = l_valid;
          win = -1;
          if (fe && le) begin win = m_ptr ? 1 : 0; m_ptr = !m_ptr; end
          else if (fe) win = 0;
          else if (le) win = 1;
          chk("busy", busy, 0);
          chk("f_ready", f_ready, win == 0);
          chk("l_ready", l_ready, win == 1);
          chk("ram_we", ram_we, win == 1 && l_we);
          if (win == 0) begin
            chk("ram_addr_f", ram_addr, f_addr);
            pend_f = 1; exp_frd = exp_mem[f_addr]; last_addr = f_addr;
          end else if (win == 1) begin
            chk("ram_addr_l", ram_addr, l_addr);
            if (l_we) chk("ram_din", ram_din, l_wdata);
            pend_l = 1; exp_lrd = exp_mem[l_addr]; last_addr = l_addr;
            if (l_we) exp_mem[l_addr] = l_wdata;
          end else begin
            chk("ram_addr_hold", ram_addr, last_addr);
          end
        end
      end
    end
  end

  task automatic lop(input logic we, input logic [8:0] a, input logic [31:0] d,
                     output logic [31:0] rd);
    int n = 0;
    l_valid = 1; l_we = we; l_addr = a; l_wdata = d;
    @(negedge clka);
    while (!l_ready && n < 1000) begin @(negedge clka); n++; end
    if (n >= 1000) begin
      checks++; errors++;
      $display("FAIL lop_timeout: actual=no_grant required=grant");
    end
    @(posedge clka); #1;
    l_valid = 0;
    @(negedge clka);
    chk("lop_rvalid", l_rvalid, 1);
    rd = l_rdata;
  endtask

  task automatic wait_clear_done();
    int bc = 0;
    while (busy && bc < 600) begin @(posedge clka); #1; bc++; end
    chk("clear_len", bc, CLR ? 512 : 0);
  endtask

  initial begin
    logic [31:0] rd;
    rsta = 1; f_valid = 0; f_addr = 0; l_valid = 0; l_we = 0;
    l_addr = 0; l_wdata = 0; l_lock = 0;
    #1;
    chk("t0_busy", busy, CLR);
    chk("t0_f_rvalid", f_rvalid, 0);
    repeat (2) @(posedge clka);
    #1 rsta = 0;
    wait_clear_done();

    // Both ports requesting continuously: strict alternation starting with fetch.
    f_valid = 1; l_valid = 1; l_we = 0;
    for (int i = 0; i < 8; i++) begin
      f_addr = 9'($urandom_range(0, 511));
      l_addr = 9'($urandom_range(0, 511));
      @(negedge clka);
      chk("rr_f_ready", f_ready, (i % 2) == 0);
      chk("rr_l_ready", l_ready, (i % 2) == 1);
      @(posedge clka); #1;
    end
    f_valid = 0; l_valid = 0;
    @(posedge clka); #1;

    // Loader write then fetch read of the same word.
    lop(1, 9'h005, 32'hDEADBEEF, rd);
    @(posedge clka); #1;
    f_valid = 1; f_addr = 9'h005;
    @(negedge clka);
    chk("fetch_ready", f_ready, 1);
    @(posedge clka); #1;
    f_valid = 0;
    @(negedge clka);
    chk("fetch_rvalid", f_rvalid, 1);
    chk("fetch_rdata", f_rdata, 32'hDEADBEEF);
    @(posedge clka); #1;

    // Lock holds off fetch while loader traffic completes.
    l_lock = 1; f_valid = 1; f_addr = 9'h010;
    for (int i = 0; i < 10; i++) begin
      l_valid = 1'($urandom_range(0, 1));
      l_we = 1'($urandom_range(0, 1));
      l_addr = 9'($urandom_range(0, 15));
      l_wdata = $urandom;
      @(negedge clka);
      chk("lock_f_ready", f_ready, 0);
      @(posedge clka); #1;
    end
    l_lock = 0; l_valid = 0;
    #1 chk("unlock_f_ready", f_ready, 1);
    @(posedge clka); #1;
    f_valid = 0;

    // Read-first write at the top address.
    lop(1, 9'h1FF, 32'h0000AAAA, rd);
    @(posedge clka); #1;
    lop(1, 9'h1FF, 32'h00001234, rd);
    chk("rf_old_word", rd, 32'h0000AAAA);
    @(posedge clka); #1;
    lop(0, 9'h1FF, 32'h0, rd);
    chk("rf_new_word", rd, 32'h00001234);
    @(posedge clka); #1;

    // Randomized traffic, checked entirely by the model.
    for (int i = 0; i < 2000; i++) begin
      f_valid = ($urandom_range(0, 3) != 0);
      l_valid = 1'($urandom_range(0, 1));
      l_we    = 1'($urandom_range(0, 1));
      l_lock  = ($urandom_range(0, 7) == 0);
      f_addr  = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 15));
      l_addr  = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 15));
      l_wdata = $urandom;
      @(posedge clka); #1;
    end
    f_valid = 0; l_valid = 0; l_lock = 0;
    @(posedge clka); #1;

    // Reset between a fetch accept and its response edge.
    f_valid = 1; f_addr = 9'h003;
    @(negedge clka);
    chk("pre_rst_f_ready", f_ready, 1);
    #1 rsta = 1; f_valid = 0;
    #1 chk("rst_now_f_rvalid", f_rvalid, 0);
    @(posedge clka); #1;
    chk("rst_drop_f_rvalid", f_rvalid, 0);
    @(posedge clka); #1;
    rsta = 0;
    #1;
    chk("post_rst_ram_addr", ram_addr, 0);
    chk("post_rst_busy", busy, CLR);
    f_valid = 1; f_addr = 9'h007;
    #1 chk("post_rst_f_ready", f_ready, !CLR);
    @(posedge clka); #1;
    f_valid = 0;
    wait_clear_done();
    repeat (3) @(posedge clka);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
